frac_clken_gen: RTL and testbench

FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

---
 rtl/frac_clken_gen_pkg.sv | 13 +
 rtl/frac_clken_chan.sv | 46 ++++
 rtl/frac_clken_gen.sv | 94 +++++++++
 tb/tb_frac_clken_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/frac_clken_gen_pkg.sv
// rtl/frac_clken_gen_pkg.sv - shared types and limits for the fractional clock-enable generator
package frac_clken_gen_pkg;

    localparam int MAX_CLOCKS = 8;
    localparam int CHAN_W     = 3;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/frac_clken_chan.sv
// rtl/frac_clken_chan.sv - one phase-accumulator channel: inc/acc registers and carry-out
module frac_clken_chan #(
    parameter int              ACC_W    = 32,
    parameter logic [ACC_W-1:0] INC_INIT = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    output logic             carry
);

    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        carry = sum[ACC_W];
        acc_d = acc_q;
        inc_d = inc_q;
        if (run) begin
            acc_d = sum[ACC_W-1:0];
        end
        // A config write realigns every channel to a common zero phase.
        if (clear) begin
            acc_d = '0;
        end
        if (load) begin
            inc_d = load_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q <= INC_INIT;
            acc_q <= '0;
        end else begin
            inc_q <= inc_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/frac_clken_gen.sv
// rtl/frac_clken_gen.sv - multi-channel fractional clock-enable generator with settle/lock FSM
module frac_clken_gen
    import frac_clken_gen_pkg::*;
#(
    parameter int                          NUM_CLOCKS    = 2,
    parameter int                          ACC_W         = 32,
    parameter int                          SETTLE_CYCLES = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_INIT      = {NUM_CLOCKS{{1'b1, {(ACC_W-1){1'b0}}}}}
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]      cfg_inc,
    output logic [NUM_CLOCKS-1:0] clken,
    output logic                  locked
);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    locked_q, locked_d;
    logic [NUM_CLOCKS-1:0]   clken_q, clken_d;
    logic [NUM_CLOCKS-1:0]   carry;
    logic                    cfg_fire;
    logic                    cfg_hit;
    logic                    run;

    always_comb begin
        cfg_ready = (state_q != ST_RESET);
        run       = (state_q != ST_RESET);
        cfg_fire  = cfg_valid & cfg_ready;
        // Writes to absent channels are accepted but otherwise ignored.
        cfg_hit   = cfg_fire & (int'(cfg_chan) < NUM_CLOCKS);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_RESET;
        endcase
        if (cfg_hit) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
        end

        locked_d = (state_d == ST_LOCKED);
        clken_d  = carry & {NUM_CLOCKS{locked_d}};
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            clken_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            clken_q  <= clken_d;
        end
    end

    assign clken  = clken_q;
    assign locked = locked_q;

    for (genvar c = 0; c < NUM_CLOCKS; c++) begin : g_chan
        frac_clken_chan #(
            .ACC_W    (ACC_W),
            .INC_INIT (INC_INIT[c*ACC_W +: ACC_W])
        ) u_chan (
            .clk      (refclk),
            .rst      (rst),
            .run      (run),
            .clear    (cfg_hit),
            .load     (cfg_hit && (cfg_chan == CHAN_W'(c))),
            .load_inc (cfg_inc),
            .carry    (carry[c])
        );
    end

endmodule

// File: tb/tb_frac_clken_gen.sv
// tb/tb_frac_clken_gen.sv - scoreboard bench for frac_clken_gen
module tb_frac_clken_gen;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_chan;
    logic [31:0] cfg_inc;
    logic [1:0]  clken;
    logic        locked;

    frac_clken_gen dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .clken     (clken),
        .locked    (locked)
    );

    always #10 refclk = ~refclk;

    typedef struct {int s; int e; int lo0; int hi0; int lo1; int hi1;} win_t;
    typedef struct {int c; logic l; logic [1:0] k; logic r;} lvl_t;

    win_t win_q[$];
    lvl_t lvl_q[$];
    int   lock_q[$];
    int   fall_q[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   tot0 = 0, tot1 = 0, snap0 = 0, snap1 = 0;
    int   rst_chk_n = 0;
    logic locked_d = 1'b0;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d..%0d", nm, cyc, act, lo, hi);
        end
    endtask

    // Monitor: observes outputs on the falling edge and retires expectations.
    always @(negedge refclk) begin
        int e;
        tot0 += int'(clken[0]);
        tot1 += int'(clken[1]);
        if (locked === 1'b1 && locked_d === 1'b0) begin
            if (lock_q.size() == 0) chk("lock_rise_unexpected", cyc, -1, -1);
            else begin
                e = lock_q.pop_front();
                chk("lock_rise", cyc, e, e);
            end
        end
        if (locked === 1'b0 && locked_d === 1'b1) begin
            if (fall_q.size() == 0) chk("lock_fall_unexpected", cyc, -1, -1);
            else begin
                e = fall_q.pop_front();
                chk("lock_fall", cyc, e, e);
            end
        end
        locked_d = locked;
        if (win_q.size() > 0 && win_q[0].e == cyc) begin
            chk($sformatf("win%0d_ch0", cyc), tot0 - snap0, win_q[0].lo0, win_q[0].hi0);
            chk($sformatf("win%0d_ch1", cyc), tot1 - snap1, win_q[0].lo1, win_q[0].hi1);
            void'(win_q.pop_front());
        end
        if (win_q.size() > 0 && win_q[0].s == cyc) begin
            snap0 = tot0;
            snap1 = tot1;
        end
        if (lvl_q.size() > 0 && lvl_q[0].c == cyc) begin
            chk("lvl_locked", int'(locked), int'(lvl_q[0].l), int'(lvl_q[0].l));
            chk("lvl_clken", int'(clken), int'(lvl_q[0].k), int'(lvl_q[0].k));
            chk("lvl_cfg_ready", int'(cfg_ready), int'(lvl_q[0].r), int'(lvl_q[0].r));
            void'(lvl_q.pop_front());
        end
    end

    always @(posedge rst) begin
        if (rst_chk_n > 0) begin
            rst_chk_n = rst_chk_n - 1;
            #1;
            chk("async_locked", int'(locked), 0, 0);
            chk("async_clken", int'(clken), 0, 0);
            chk("async_cfg_ready", int'(cfg_ready), 0, 0);
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    task automatic wr(input int ch, input logic [31:0] inc);
        cfg_valid = 1'b1;
        cfg_chan  = 3'(ch);
        cfg_inc   = inc;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = 3'd0;
        cfg_inc   = 32'd0;

        // Expectations for the whole run, hand-computed from the cycle plan below.
        lvl_q.push_back('{2, 1'b0, 2'b00, 1'b0});
        lvl_q.push_back('{19, 1'b1, 2'b11, 1'b1});
        lvl_q.push_back('{16479, 1'b1, 2'b01, 1'b1});
        lvl_q.push_back('{26631, 1'b0, 2'b00, 1'b1});
        lock_q = '{19, 67, 16479, 26534, 26607, 26647};
        fall_q = '{51, 16461, 26491, 26591, 26631};
        win_q.push_back('{2, 18, 0, 0, 0, 0});
        win_q.push_back('{18, 38, 10, 10, 10, 10});
        win_q.push_back('{50, 66, 0, 0, 0, 0});
        win_q.push_back('{66, 16450, 8249, 8250, 8192, 8192});
        win_q.push_back('{16460, 16478, 0, 0, 0, 0});
        win_q.push_back('{16478, 26478, 2500, 2500, 0, 0});
        win_q.push_back('{26490, 26533, 0, 0, 0, 0});
        win_q.push_back('{26533, 26553, 10, 10, 10, 10});
        win_q.push_back('{26560, 26580, 10, 10, 10, 10});
        win_q.push_back('{26646, 26666, 10, 10, 10, 10});

        wait_to(2);
        rst = 1'b0;

        wait_to(50);
        wr(0, 32'h80E6_3C0A);

        // Consecutive writes: chan1 then chan0 then chan1 again; last one wins for chan1.
        wait_to(16460);
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_inc = 32'h4000_0000;
        @(negedge refclk);
        cfg_chan = 3'd0; cfg_inc = 32'h4000_0000;
        @(negedge refclk);
        cfg_chan = 3'd1; cfg_inc = 32'h0000_0000;
        @(negedge refclk);
        cfg_valid = 1'b0;

        wait_to(26490);
        wr(0, 32'h8000_0000);
        wait_to(26501);
        wr(1, 32'h8000_0000);
        wait_to(26517);
        wr(0, 32'h8000_0000);

        wait_to(26560);
        wr(7, 32'h0000_0000);

        wait_to(26590);
        wr(1, 32'h0000_0000);

        wait_to(26630);
        rst_chk_n = rst_chk_n + 1;
        #2 rst = 1'b1;
        #5 rst = 1'b0;

        wait_to(26680);
        chk("lock_q_left", lock_q.size(), 0, 0);
        chk("fall_q_left", fall_q.size(), 0, 0);
        chk("win_q_left", win_q.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
